// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Imported by the interface, the baud counter and the top level.
package fifo_uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status of the transmitter.
// master = transmitter, slave = FIFO/host side.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              ENABLE;
  logic              F_EMPTY_N;
  logic [DATA_W-1:0] FIFO_DATA;
  logic              READ;
  logic              TX;
  logic              BUSY;
  logic              TX_DONE;

  modport master (
    input  ENABLE,
    input  F_EMPTY_N,
    input  FIFO_DATA,
    output READ,
    output TX,
    output BUSY,
    output TX_DONE
  );

  modport slave (
    output ENABLE,
    output F_EMPTY_N,
    output FIFO_DATA,
    input  READ,
    input  TX,
    input  BUSY,
    input  TX_DONE
  );

endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles.
// BIT_END marks the last cycle of each serial bit.
module baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic CLR,
  output logic BIT_END
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign BIT_END = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (CLR || BIT_END) cnt_d = '0;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and sends each one as an 8N1 frame.
// A byte is popped only when the serializer can start on it.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  input  logic           CLEAR_N,
  fifo_uart_tx_if.master bus
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IDX_W-1:0]  idx_q;
  logic              read_q;
  logic              tx_q;
  logic              bit_end;
  logic              clr;
  logic              go;

  assign go  = bus.ENABLE & bus.F_EMPTY_N;
  assign clr = !CLEAR_N || (state_q == LOAD);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .CLR    (clr),
    .BIT_END(bit_end)
  );

  assign bus.READ    = read_q;
  assign bus.TX      = tx_q;
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.TX_DONE = (state_q == STOP) && bit_end;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      read_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (!CLEAR_N) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      read_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      read_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (go) begin
            state_q <= POP;
            read_q  <= 1'b1;
          end
        end
        POP: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shreg_q <= bus.FIFO_DATA;
          idx_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_IDX) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              // Next bit is shreg[1] before the shift lands.
              shreg_q <= shreg_q >> 1;
              tx_q    <= shreg_q[1];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (go) begin
              state_q <= POP;
              read_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the 8-bit, 32-entry FIFO: pops one byte at a time from the FIFO read port and transmits it as an asynchronous 8N1 serial frame (start bit, 8 data bits LSB first, stop bit). It sits downstream of the FIFO and is the only agent allowed to drive the FIFO `READ` input. A byte is removed from the FIFO only when the serializer is ready to send it.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: `CLOCK` cycles per serial bit (50 MHz / 115200). Legal range ≥ 2.

Ports:
- `CLOCK`, input, 1: single system clock; all logic is on the rising edge.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `CLEAR_N`, input, 1: synchronous active-low clear; same effect as reset, applied at a clock edge.
- `ENABLE`, input, 1: permits starting new frames.
- `F_EMPTY_N`, input, 1: FIFO not-empty flag.
- `FIFO_DATA`, input, 8: FIFO `DATA_OUT`; valid the cycle after `READ` is sampled high.
- `READ`, output, 1: FIFO pop strobe; one-cycle pulse per byte.
- `TX`, output, 1: serial line; idles high.
- `BUSY`, output, 1: high whenever the FSM is not in IDLE.
- `TX_DONE`, output, 1: one-cycle pulse on the last cycle of each stop bit.

## Operation

- Reset values: `READ`=0, `TX`=1, `BUSY`=0, `TX_DONE`=0, state IDLE, counters 0.
- The FSM has six states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: if `ENABLE`=1 and `F_EMPTY_N`=1 at the edge, go to POP.
- POP: lasts one cycle with `READ`=1 (Moore output, registered). Next state is LOAD.
- LOAD: lasts one cycle. Capture `FIFO_DATA` into an 8-bit shift register and clear the baud counter. Next state is START.
- START: `TX`=0 for `CLKS_PER_BIT` cycles. Next state is DATA.
- DATA: `TX`=shreg[0] for `CLKS_PER_BIT` cycles per bit. Shift right at each bit boundary, with bit index 0..7. After bit 7, go to STOP.
- STOP: `TX`=1 for `CLKS_PER_BIT` cycles; `TX_DONE`=1 on the final cycle. On that final cycle:
  - if `ENABLE`=1 and `F_EMPTY_N`=1, go directly to POP;
  - otherwise go to IDLE.
- `TX`=1 in IDLE, POP, LOAD and STOP.
- The baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. It is cleared when entering START.
- Deasserting `ENABLE` mid-frame does not abort: the current frame completes, and no further POP follows.
- `CLEAR_N`=0 at an edge forces the reset values next cycle, from any state:
  - a frame in progress is truncated (`TX` returns high);
  - a byte already popped is discarded, not re-queued;
  - `CLEAR_N` has priority over all transitions.
- Asynchronous reset mid-frame behaves identically, taking effect immediately without waiting for an edge.
- `READ` is never asserted unless `F_EMPTY_N` was 1 on the preceding edge. Since this block is the sole reader, the FIFO cannot underflow.

## Timing

- Pop-to-line latency: `F_EMPTY_N` is sampled at edge k. `READ` is high during cycle k+1, LOAD is cycle k+2, and the start bit begins in cycle k+3.
- Frame on the line is exactly 10×`CLKS_PER_BIT` cycles (start, 8 data, stop).
- Back-to-back frames have a 2-cycle idle-high gap (POP, LOAD) between the stop bit and the next start bit. Period = 10×`CLKS_PER_BIT`+2 cycles.
- `TX_DONE` is coincident with the last stop-bit cycle. `BUSY` falls on the cycle after that if no next byte is popped.

## Structure

- Package `fifo_uart_pkg` holds:
  - the `state_t` enum (IDLE, POP, LOAD, START, DATA, STOP);
  - `DATA_W`=8;
  - `FRAME_BITS`=10.
- Sub-module `baud_counter`, parameterised by `CLKS_PER_BIT`, with inputs `CLOCK`, `RESET_N`, `CLR` and output `BIT_END` (a one-cycle pulse when count = `CLKS_PER_BIT`-1).
- The top level holds the FSM, shift register, bit index and the output registers.

## Test plan

All scenarios use `CLKS_PER_BIT`=4, with the real FIFO instanced in the bench.

- Reset state: assert `RESET_N`=0 → `TX`=1, `READ`=0, `BUSY`=0 and `TX_DONE`=0 immediately.
- Single byte: write 0xA5, `ENABLE`=1 →
  - one `READ` pulse;
  - start bit 3 cycles after `F_EMPTY_N` rises;
  - `TX` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - one `TX_DONE`; FIFO empty afterwards.
- Burst: write 0x01, 0x02, 0x03 → three frames with exactly 2 idle-high cycles between them, 3 `READ` pulses and 3 `TX_DONE` pulses.
- Enable gating:
  - `ENABLE`=0 with FIFO holding 0x55 → no `READ`, `TX` stays 1 and `USE_DW` stays 1;
  - raising `ENABLE` → the frame is sent.
- Clear mid-frame: pulse `CLEAR_N` during DATA bit 3 of 0xFF →
  - `TX`=1 and `BUSY`=0 next cycle;
  - `USE_DW` unchanged by the clear;
  - the next FIFO byte is sent as a complete frame.
- Drain full FIFO: 32 random writes →
  - exactly 32 frames, whose decoded bytes match in write order;
  - `F_EMPTY_N`=0 at the end;
  - no `READ` pulse while empty.
